// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : des_key_sched
//  Function : Sequential DES key schedule. Accepts a 64-bit key, applies
//             PC-1, then streams the sixteen 48-bit round subkeys one per
//             consumer handshake in encrypt (K1..K16) or decrypt (K16..K1)
//             order.
//  Revision : 1.0 - initial release
// ============================================================================
module des_key_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [63:0] key_in,
   input  logic        decrypt,
   input  logic        abort,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [47:0] subkey,
   output logic [4:0]  round,
   output logic        last
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GEN  = 1'b1
   } state_t;

   // PC-1 in DES bit numbering (bit 1 = key_in[63]); first 28 entries form C, rest D.
   localparam int unsigned c_pc1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   // PC-2 in DES bit numbering of the 56-bit CD (bit 1 = C msb).
   localparam int unsigned c_pc2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Bit r set means round r uses a 2-bit rotation, otherwise 1 bit.
   localparam logic [31:0] c_dbl = 32'h0000_FDF8;

   state_t      r_state;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [4:0]  r_round;
   logic        r_mode;

   logic [55:0] w_pc1;
   logic [27:0] w_c0;
   logic [27:0] w_d0;
   logic [55:0] w_cd;
   logic [47:0] w_pc2;
   logic        w_enc_two;
   logic        w_dec_two;
   logic        w_unused_parity;

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   // PC-1 wiring from the incoming key
   for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      assign w_pc1[55-gi] = key_in[64 - c_pc1[gi]];
   end

   assign w_c0 = w_pc1[55:28];
   assign w_d0 = w_pc1[27:0];

   // Parity bits (DES bits 8,16,...,64) play no part in the schedule
   assign w_unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                              key_in[24], key_in[16], key_in[8],  key_in[0]};

   // PC-2 wiring from the live C/D registers
   assign w_cd = {r_c, r_d};
   for (genvar gj = 0; gj < 48; gj++) begin : g_pc2
      assign w_pc2[47-gj] = w_cd[56 - c_pc2[gj]];
   end

   // Encrypt walks forward to round+1; decrypt undoes the shift of round 17-round
   assign w_enc_two = c_dbl[r_round + 5'd1];
   assign w_dec_two = c_dbl[5'd17 - r_round];

   // Control FSM with C/D rotation datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_round <= '0;
         r_mode  <= 1'b0;
      end else if (abort) begin
         r_state <= ST_IDLE;
         r_round <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (key_valid) begin
                  r_mode  <= decrypt;
                  r_round <= 5'd1;
                  r_state <= ST_GEN;
                  // C16D16 == C0D0, so decrypt starts from the unshifted halves
                  if (decrypt) begin
                     r_c <= w_c0;
                     r_d <= w_d0;
                  end else begin
                     r_c <= rotl28(w_c0, 1'b0);
                     r_d <= rotl28(w_d0, 1'b0);
                  end
               end
            end
            ST_GEN: begin
               if (subkey_ready) begin
                  if (r_round == 5'd16) begin
                     r_state <= ST_IDLE;
                     r_round <= '0;
                  end else begin
                     r_round <= r_round + 5'd1;
                     if (r_mode) begin
                        r_c <= rotr28(r_c, w_dec_two);
                        r_d <= rotr28(r_d, w_dec_two);
                     end else begin
                        r_c <= rotl28(r_c, w_enc_two);
                        r_d <= rotl28(r_d, w_enc_two);
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode directly from registered state
   assign key_ready    = (r_state == ST_IDLE);
   assign subkey_valid = (r_state == ST_GEN);
   assign subkey       = subkey_valid ? w_pc2 : '0;
   assign round        = r_round;
   assign last         = subkey_valid && (r_round == 5'd16);

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_key_sched
//  Function : Self-checking bench for des_key_sched. A key-schedule model
//             built from cumulative rotations tracks every handshake and is
//             compared against the DUT on each falling edge; directed tests
//             pin literal subkeys.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic [63:0] key_in = '0;
   logic        decrypt = 1'b0;
   logic        abort = 1'b0;
   logic        subkey_valid;
   logic        subkey_ready = 1'b0;
   logic [47:0] subkey;
   logic [4:0]  round;
   logic        last;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_PAR = 64'h123556789ABDDEF0;
   localparam logic [63:0] KEY2    = 64'h0E329232EA6D0D73;
   localparam logic [47:0] K1_LIT  = 48'h1B02EFFC7072;
   localparam logic [47:0] K2_LIT  = 48'h79AED9DBC9E5;
   localparam logic [47:0] K16_LIT = 48'hCB3D8B0E17F5;

   int m_pc1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   int m_pc2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   int m_shift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic [47:0] exp_keys [16];
   logic [47:0] got      [16];
   logic [47:0] ref_enc  [16];
   bit          exp_active = 1'b0;
   bit          exp_mode   = 1'b0;
   int          exp_idx    = 0;

   always #5 clk = ~clk;

   des_key_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .key_in       (key_in),
      .decrypt      (decrypt),
      .abort        (abort),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .subkey       (subkey),
      .round        (round),
      .last         (last)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Key schedule model: Ki = PC-2(C0,D0 each rotated left by the sum of shifts 1..i)
   task automatic build_model(input logic [63:0] k);
      logic [27:0] c0, d0;
      logic [55:0] tc, td, cd;
      int s;
      s = 0;
      for (int i = 0; i < 28; i++) begin
         c0[27-i] = k[64 - m_pc1[i]];
         d0[27-i] = k[64 - m_pc1[28+i]];
      end
      for (int r = 0; r < 16; r++) begin
         s  = s + m_shift[r];
         tc = {c0, c0} << s;
         td = {d0, d0} << s;
         cd = {tc[55:28], td[55:28]};
         for (int j = 0; j < 48; j++)
            exp_keys[r][47-j] = cd[56 - m_pc2[j]];
      end
   endtask

   // Per-cycle compare against the model, then advance the model on the handshakes
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_active = 1'b0;
         exp_idx    = 0;
      end else begin
         if (exp_active) begin
            chk("mon_valid",  subkey_valid, 1);
            chk("mon_kready", key_ready, 0);
            chk("mon_round",  round, exp_idx + 1);
            chk("mon_subkey", subkey, exp_keys[exp_mode ? 15 - exp_idx : exp_idx]);
            chk("mon_last",   last, (exp_idx == 15) ? 1 : 0);
         end else begin
            chk("mon_idle_valid",  subkey_valid, 0);
            chk("mon_idle_kready", key_ready, 1);
            chk("mon_idle_round",  round, 0);
            chk("mon_idle_subkey", subkey, 0);
            chk("mon_idle_last",   last, 0);
         end
         if (abort) begin
            exp_active = 1'b0;
            exp_idx    = 0;
         end else if (exp_active) begin
            if (subkey_ready) begin
               if (exp_idx == 15) begin
                  exp_active = 1'b0;
                  exp_idx    = 0;
               end else begin
                  exp_idx++;
               end
            end
         end else if (key_valid) begin
            build_model(key_in);
            exp_mode   = decrypt;
            exp_active = 1'b1;
            exp_idx    = 0;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_key(input logic [63:0] k, input logic dec);
      int n;
      n = 0;
      while (key_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("key_ready_wait", key_ready, 1);
      key_in    = k;
      decrypt   = dec;
      key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      key_in    = '0;
      decrypt   = 1'b0;
      chk("accept_valid", subkey_valid, 1);
      chk("accept_round", round, 1);
   endtask

   // Consume a full stream, optionally with random 0-5 cycle stalls per subkey
   task automatic collect(input bit stalls, output int vcyc);
      int  cyc;
      int  stall_left;
      bit  done;
      cyc  = 0;
      vcyc = 0;
      done = 1'b0;
      for (int i = 0; i < 16; i++) got[i] = '0;
      stall_left = stalls ? int'($urandom_range(0, 5)) : 0;
      while (!done && cyc < 300) begin
         subkey_ready = (stall_left == 0);
         @(negedge clk);
         if (subkey_valid) begin
            vcyc++;
            if (subkey_ready) begin
               if (round >= 5'd1 && round <= 5'd16) got[round - 5'd1] = subkey;
               if (last) done = 1'b1;
               stall_left = stalls ? int'($urandom_range(0, 5)) : 0;
            end else begin
               stall_left--;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      subkey_ready = 1'b0;
      chk("stream_done", done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vc;

      // Model pinned against known FIPS example subkeys
      build_model(KEY);
      chk("model_k1",  exp_keys[0],  K1_LIT);
      chk("model_k2",  exp_keys[1],  K2_LIT);
      chk("model_k16", exp_keys[15], K16_LIT);

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_kready", key_ready, 1);
      chk("rst_valid",  subkey_valid, 0);
      chk("rst_subkey", subkey, 0);
      chk("rst_round",  round, 0);
      chk("rst_last",   last, 0);
      @(posedge clk); #1;

      // Encrypt stream, ready held high
      send_key(KEY, 1'b0);
      collect(1'b0, vc);
      chk("enc_vcycles", vc, 16);
      chk("enc_k1",  got[0],  K1_LIT);
      chk("enc_k2",  got[1],  K2_LIT);
      chk("enc_k16", got[15], K16_LIT);
      chk("enc_end_kready", key_ready, 1);
      chk("enc_end_valid",  subkey_valid, 0);
      for (int i = 0; i < 16; i++) ref_enc[i] = got[i];

      // Decrypt stream
      send_key(KEY, 1'b1);
      collect(1'b0, vc);
      chk("dec_vcycles", vc, 16);
      chk("dec_r1",  got[0],  K16_LIT);
      chk("dec_r15", got[14], K2_LIT);
      chk("dec_r16", got[15], K1_LIT);
      for (int i = 0; i < 16; i++) chk("dec_vs_enc", got[i], ref_enc[15-i]);

      // Backpressure
      send_key(KEY, 1'b0);
      collect(1'b1, vc);
      for (int i = 0; i < 16; i++) chk("bp_seq", got[i], ref_enc[i]);

      // Abort and ignored keys
      send_key(KEY, 1'b0);
      subkey_ready = 1'b1;
      @(posedge clk); #1;
      key_in = KEY2; decrypt = 1'b1; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0; key_in = '0; decrypt = 1'b0;
      chk("gen_key_ignored_round", round, 3);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_abort_round", round, 7);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      subkey_ready = 1'b0;
      chk("abort_valid",  subkey_valid, 0);
      chk("abort_round",  round, 0);
      chk("abort_kready", key_ready, 1);
      abort = 1'b1; key_valid = 1'b1; key_in = KEY2;
      @(posedge clk); #1;
      abort = 1'b0; key_valid = 1'b0; key_in = '0;
      chk("abort_key_valid", subkey_valid, 0);
      chk("abort_key_kready", key_ready, 1);
      send_key(KEY, 1'b0);
      collect(1'b0, vc);
      chk("post_abort_k1", got[0], K1_LIT);
      chk("post_abort_k2", got[1], K2_LIT);

      // Parity independence
      send_key(KEY_PAR, 1'b0);
      collect(1'b0, vc);
      for (int i = 0; i < 16; i++) chk("parity_seq", got[i], ref_enc[i]);

      // Asynchronous reset mid-stream
      send_key(KEY, 1'b0);
      subkey_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      subkey_ready = 1'b0;
      chk("pre_rst_round", round, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid",  subkey_valid, 0);
      chk("arst_round",  round, 0);
      chk("arst_subkey", subkey, 0);
      chk("arst_last",   last, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("arst_rel_kready", key_ready, 1);
      @(posedge clk); #1;
      chk("arst_no_resume", subkey_valid, 0);
      send_key(KEY, 1'b0);
      collect(1'b0, vc);
      chk("arst_new_k1",  got[0],  K1_LIT);
      chk("arst_new_k16", got[15], K16_LIT);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
